// File: rtl/network_sequencer.sv
// network_sequencer: steps the shared neuron array through LAYER_MAX layers per run, feeding each layer's outputs forward.
// Define SEQ_TIMEOUT_EN to abort a layer that stalls for TIMEOUT wait cycles and raise the sticky error flag.
module network_sequencer #(
    parameter int NUM_NEURON = 6,
    parameter int VALUE_SIZE = 9,
    parameter int LAYER_MAX = 4,
    parameter logic [NUM_NEURON*LAYER_MAX-1:0] LAYER_SIZES = {6'b101010, 6'b111010, 6'b111110, 6'b111111},
    parameter int TIMEOUT = 1023
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_NEURON*VALUE_SIZE-1:0] start_input,
    input  logic [NUM_NEURON*VALUE_SIZE-1:0] neuron_output,
    input  logic [NUM_NEURON-1:0]            neuron_valid,
    output logic                             busy,
    output logic                             layer_start,
    output logic [$clog2(LAYER_MAX):0]       layer_num,
    output logic [NUM_NEURON-1:0]            active,
    output logic [NUM_NEURON*VALUE_SIZE-1:0] layer_input,
    output logic                             done,
    output logic [NUM_NEURON*VALUE_SIZE-1:0] result,
    output logic                             error
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

    state_t state, state_d;
    logic [NUM_NEURON-1:0] seen, fresh;
    logic [NUM_NEURON*VALUE_SIZE-1:0] collect, merged;
    logic complete, last, timed_out;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("TIMEOUT must be at least 1");
    end

    assign active = LAYER_SIZES[int'(layer_num)*NUM_NEURON +: NUM_NEURON];
    assign fresh = neuron_valid & active & ~seen;
    assign complete = (seen | (neuron_valid & active)) == active;
    assign last = int'(layer_num) == LAYER_MAX - 1;
    assign busy = state != IDLE;
    assign layer_start = state == LAUNCH;
    assign done = state == DONE;

    // collect is zero on every lane not yet seen, so only this cycle's new strobes need merging
    always_comb begin
        merged = collect;
        for (int i = 0; i < NUM_NEURON; i++)
            if (fresh[i]) merged[i*VALUE_SIZE +: VALUE_SIZE] = neuron_output[i*VALUE_SIZE +: VALUE_SIZE];
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start ? LAUNCH : IDLE;
            LAUNCH:  state_d = WAIT;
            WAIT:    state_d = complete ? (last ? DONE : LAUNCH) : (timed_out ? IDLE : WAIT);
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            layer_input <= '0;
            layer_num <= '0;
            seen <= '0;
            collect <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    layer_input <= start_input;
                    layer_num <= '0;
                end
                LAUNCH: begin
                    seen <= '0;
                    collect <= '0;
                end
                WAIT: begin
                    seen <= seen | fresh;
                    collect <= merged;
                    if (complete && !last) begin
                        layer_input <= merged;
                        layer_num <= layer_num + 1'b1;
                    end
                    if (complete && last) result <= merged;
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic [$clog2(TIMEOUT+1)-1:0] wait_cnt;

    assign timed_out = state == WAIT && !complete && int'(wait_cnt) == TIMEOUT - 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            error <= 1'b0;
        end else begin
            if (state == IDLE && start) error <= 1'b0;
            else if (timed_out) error <= 1'b1;
            if (state == LAUNCH) wait_cnt <= '0;
            else if (state == WAIT && !complete) wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
    assign error = 1'b0;
`endif
endmodule
